// File: rtl/dut_system_pkg.sv
// Shared pixel types and the RGB-to-gray helper for the pixel pipeline.
// Pixel byte order on the wire is B,G,R: byte0=[23:16], byte1=[15:8], byte2=[7:0].
package dut_system_pkg;

    localparam int CHAN_W  = 8;
    localparam int PIXEL_W = 24;
    localparam int GRAY_W  = 8;

    typedef struct packed {
        logic [CHAN_W-1:0] b0;
        logic [CHAN_W-1:0] b1;
        logic [CHAN_W-1:0] b2;
    } pixel_t;

    // Average variant is exact floor(sum/3); weighted variant is a BT.601-style luma with R in byte2.
    function automatic logic [GRAY_W-1:0] rgb_to_gray(input pixel_t px, input logic weighted);
        logic [9:0]  sum;
        logic [15:0] wsum;
        logic [9:0]  avg;
        sum  = {2'b00, px.b0} + {2'b00, px.b1} + {2'b00, px.b2};
        avg  = sum / 10'd3;
        wsum = 16'd77  * {8'd0, px.b2}
             + 16'd150 * {8'd0, px.b1}
             + 16'd29  * {8'd0, px.b0};
        if (weighted)
            return wsum[15:8];
        else
            return avg[GRAY_W-1:0];
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO of any depth >= 2; dout shows the head (0 when empty).
// Flags are registered from the next count; writes while full and reads while empty are ignored.
module sync_fifo_fwft #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DWIDTH-1:0] din,
    input  logic              wr_en,
    output logic              full,
    output logic [DWIDTH-1:0] dout,
    input  logic              rd_en,
    output logic              empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic              wr_fire;
    logic              rd_fire;

    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;

    // Explicit wrap so non-power-of-two depths never address past DEPTH-1.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        count_nxt = count;
        case ({wr_fire, rd_fire})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_fire)
                wr_ptr <= next_ptr(wr_ptr);
            if (rd_fire)
                rd_ptr <= next_ptr(rd_ptr);
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && wr_fire)
            mem[wr_ptr] <= din;
    end

    assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/dut_system.sv
// Pixel pipeline: input FIFO -> gray/passthrough converter -> output FIFO, one word per cycle.
// Write at edge N lands in the output FIFO at edge N+1; optional weighted gray via DUT_SYSTEM_WEIGHTED_GRAY_EN.
module dut_system
    import dut_system_pkg::*;
#(
    parameter int CONVERT_GRAYSCALE = 1,
    parameter int FIFO_DWIDTH_IN    = 24,
    parameter int FIFO_DWIDTH_OUT   = 8,
    parameter int FIFO_BUFFER_SIZE  = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [FIFO_DWIDTH_IN-1:0]  fifo_in_din,
    input  logic                       fifo_in_wr_en,
    output logic                       fifo_in_full,
    output logic [FIFO_DWIDTH_OUT-1:0] fifo_out_dout,
    input  logic                       fifo_out_rd_en,
    output logic                       fifo_out_empty
);

`ifdef DUT_SYSTEM_WEIGHTED_GRAY_EN
    localparam logic WEIGHTED = 1'b1;
`else
    localparam logic WEIGHTED = 1'b0;
`endif

    logic [FIFO_DWIDTH_IN-1:0]  in_head;
    logic                       in_empty;
    logic                       out_full;
    logic                       xfer;
    logic [FIFO_DWIDTH_OUT-1:0] conv;

    sync_fifo_fwft #(
        .DWIDTH (FIFO_DWIDTH_IN),
        .DEPTH  (FIFO_BUFFER_SIZE)
    ) u_fifo_in (
        .clock (clock),
        .reset (reset),
        .din   (fifo_in_din),
        .wr_en (fifo_in_wr_en),
        .full  (fifo_in_full),
        .dout  (in_head),
        .rd_en (xfer),
        .empty (in_empty)
    );

    // Move one word whenever there is something to move and room to put it.
    assign xfer = !in_empty && !out_full;

    generate
        if (CONVERT_GRAYSCALE != 0) begin : g_gray
            assign conv = FIFO_DWIDTH_OUT'(rgb_to_gray(pixel_t'(in_head), WEIGHTED));
        end else begin : g_pass
            assign conv = FIFO_DWIDTH_OUT'(in_head);
        end
    endgenerate

    sync_fifo_fwft #(
        .DWIDTH (FIFO_DWIDTH_OUT),
        .DEPTH  (FIFO_BUFFER_SIZE)
    ) u_fifo_out (
        .clock (clock),
        .reset (reset),
        .din   (conv),
        .wr_en (xfer),
        .full  (out_full),
        .dout  (fifo_out_dout),
        .rd_en (fifo_out_rd_en),
        .empty (fifo_out_empty)
    );

endmodule

// File: tb/tb_dut_system.sv
// Directed bench for dut_system: gray instance (depth 2) and passthrough instance (depth 3).
module tb_dut_system;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic [23:0] g_din = '0;
    logic        g_wr  = 1'b0;
    logic        g_full;
    logic [7:0]  g_dout;
    logic        g_rd  = 1'b0;
    logic        g_empty;

    logic [23:0] p_din = '0;
    logic        p_wr  = 1'b0;
    logic        p_full;
    logic [23:0] p_dout;
    logic        p_rd  = 1'b0;
    logic        p_empty;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    dut_system #(
        .CONVERT_GRAYSCALE (1),
        .FIFO_DWIDTH_IN    (24),
        .FIFO_DWIDTH_OUT   (8),
        .FIFO_BUFFER_SIZE  (2)
    ) u_gray (
        .clock          (clock),
        .reset          (reset),
        .fifo_in_din    (g_din),
        .fifo_in_wr_en  (g_wr),
        .fifo_in_full   (g_full),
        .fifo_out_dout  (g_dout),
        .fifo_out_rd_en (g_rd),
        .fifo_out_empty (g_empty)
    );

    dut_system #(
        .CONVERT_GRAYSCALE (0),
        .FIFO_DWIDTH_IN    (24),
        .FIFO_DWIDTH_OUT   (24),
        .FIFO_BUFFER_SIZE  (3)
    ) u_pass (
        .clock          (clock),
        .reset          (reset),
        .fifo_in_din    (p_din),
        .fifo_in_wr_en  (p_wr),
        .fifo_in_full   (p_full),
        .fifo_out_dout  (p_dout),
        .fifo_out_rd_en (p_rd),
        .fifo_out_empty (p_empty)
    );

    function automatic logic [7:0] avg_gray(input logic [23:0] w);
        int s;
        s = int'(w[23:16]) + int'(w[15:8]) + int'(w[7:0]);
        return 8'(s / 3);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++;
        if (g_full !== 1'b0 || g_empty !== 1'b1 || g_dout !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_gray: full=%b empty=%b dout=%h, want 0 1 00", g_full, g_empty, g_dout);
        end
        vectors++;
        if (p_full !== 1'b0 || p_empty !== 1'b1 || p_dout !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_pass: full=%b empty=%b dout=%h, want 0 1 000000", p_full, p_empty, p_dout);
        end
    endtask

    task automatic test_latency();
        g_din = 24'h306090;
        g_wr  = 1'b1;
        tick();
        g_wr = 1'b0;
        vectors++;
        if (g_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_edge1: empty=%b, want 1", g_empty);
        end
        tick();
        vectors++;
        if (g_empty !== 1'b0 || g_dout !== 8'h60) begin
            miscompares++;
            $display("FAIL latency_edge2: empty=%b dout=%h, want 0 60", g_empty, g_dout);
        end
        g_rd = 1'b1;
        tick();
        g_rd = 1'b0;
        vectors++;
        if (g_empty !== 1'b1 || g_dout !== 8'h00) begin
            miscompares++;
            $display("FAIL latency_pop: empty=%b dout=%h, want 1 00", g_empty, g_dout);
        end
    endtask

    task automatic test_gray_vectors();
        logic [23:0] vin [8];
        logic [7:0]  vexp [8];
        vin[0] = 24'hFFFFFF; vexp[0] = 8'hFF;
        vin[1] = 24'h000000; vexp[1] = 8'h00;
        vin[2] = 24'h010000; vexp[2] = 8'h00;
        vin[3] = 24'h020201; vexp[3] = 8'h01;
        vin[4] = 24'hFF0000; vexp[4] = 8'h55;
        vin[5] = 24'hFFFF00; vexp[5] = 8'hAA;
        vin[6] = 24'h00FFFE; vexp[6] = 8'hA9;
        vin[7] = 24'h000102; vexp[7] = 8'h01;
        for (int i = 0; i < 8; i++) begin
            g_din = vin[i];
            g_wr  = 1'b1;
            tick();
            g_wr = 1'b0;
            tick();
            vectors++;
            if (g_empty !== 1'b0 || g_dout !== vexp[i]) begin
                miscompares++;
                $display("FAIL gray_vec[%0d] in=%h: empty=%b dout=%h, want 0 %h", i, vin[i], g_empty, g_dout, vexp[i]);
            end
            g_rd = 1'b1;
            tick();
            g_rd = 1'b0;
        end
    endtask

    task automatic test_passthrough();
        p_din = 24'hABCDEF;
        p_wr  = 1'b1;
        tick();
        p_din = 24'h123456;
        tick();
        p_wr = 1'b0;
        tick();
        vectors++;
        if (p_empty !== 1'b0 || p_dout !== 24'hABCDEF) begin
            miscompares++;
            $display("FAIL pass_first: empty=%b dout=%h, want 0 abcdef", p_empty, p_dout);
        end
        p_rd = 1'b1;
        tick();
        p_rd = 1'b0;
        vectors++;
        if (p_empty !== 1'b0 || p_dout !== 24'h123456) begin
            miscompares++;
            $display("FAIL pass_second: empty=%b dout=%h, want 0 123456", p_empty, p_dout);
        end
        p_rd = 1'b1;
        tick();
        p_rd = 1'b0;
        vectors++;
        if (p_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL pass_drained: empty=%b, want 1", p_empty);
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] win [4];
        logic [7:0]  wexp [4];
        win[0] = 24'h030303; wexp[0] = 8'h03;
        win[1] = 24'h060606; wexp[1] = 8'h06;
        win[2] = 24'h090909; wexp[2] = 8'h09;
        win[3] = 24'h0C0C0C; wexp[3] = 8'h0C;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (g_full !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_not_full[%0d]: full=%b, want 0", i, g_full);
            end
            g_din = win[i];
            g_wr  = 1'b1;
            tick();
        end
        g_wr = 1'b0;
        vectors++;
        if (g_full !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_full: full=%b, want 1", g_full);
        end
        g_din = 24'h777777;
        g_wr  = 1'b1;
        tick();
        g_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (g_empty !== 1'b0 || g_dout !== wexp[i]) begin
                miscompares++;
                $display("FAIL bp_drain[%0d]: empty=%b dout=%h, want 0 %h", i, g_empty, g_dout, wexp[i]);
            end
            g_rd = 1'b1;
            tick();
            g_rd = 1'b0;
        end
        tick();
        vectors++;
        if (g_empty !== 1'b1 || g_full !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_dropped: empty=%b full=%b dout=%h, want empty 1 full 0", g_empty, g_full, g_dout);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) begin
            g_din = 24'h101010 * (i + 1);
            g_wr  = 1'b1;
            tick();
        end
        g_din = 24'h555555;
        g_rd  = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        g_wr  = 1'b0;
        g_rd  = 1'b0;
        vectors++;
        if (g_empty !== 1'b1 || g_full !== 1'b0 || g_dout !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset: empty=%b full=%b dout=%h, want 1 0 00", g_empty, g_full, g_dout);
        end
        g_din = 24'h306090;
        g_wr  = 1'b1;
        tick();
        g_wr = 1'b0;
        tick();
        vectors++;
        if (g_empty !== 1'b0 || g_dout !== 8'h60) begin
            miscompares++;
            $display("FAIL midreset_first: empty=%b dout=%h, want 0 60", g_empty, g_dout);
        end
        g_rd = 1'b1;
        tick();
        g_rd = 1'b0;
        vectors++;
        if (g_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_extra: empty=%b dout=%h, want empty 1", g_empty, g_dout);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  gq [$];
        logic [23:0] pq [$];
        logic [7:0]  ge;
        logic [23:0] pe;
        int          budget;
        int          g_bad = 0;
        int          p_bad = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            g_wr = !g_full && (cyc < 500 || $urandom_range(0, 3) != 0);
            g_rd = !g_empty && (cyc < 500 || $urandom_range(0, 2) != 0);
            p_wr = !p_full && ($urandom_range(0, 2) != 0);
            p_rd = !p_empty && ($urandom_range(0, 3) != 0);
            g_din = 24'($urandom);
            p_din = 24'($urandom);
            if (g_wr) gq.push_back(avg_gray(g_din));
            if (p_wr) pq.push_back(p_din);
            if (g_rd) begin
                ge = (gq.size() > 0) ? gq.pop_front() : 8'hxx;
                vectors++;
                if (g_dout !== ge) begin
                    miscompares++;
                    if (g_bad++ < 5)
                        $display("FAIL stream_gray cyc %0d: dout=%h, want %h", cyc, g_dout, ge);
                end
            end
            if (p_rd) begin
                pe = (pq.size() > 0) ? pq.pop_front() : 24'hxxxxxx;
                vectors++;
                if (p_dout !== pe) begin
                    miscompares++;
                    if (p_bad++ < 5)
                        $display("FAIL stream_pass cyc %0d: dout=%h, want %h", cyc, p_dout, pe);
                end
            end
            tick();
        end
        g_wr = 1'b0;
        p_wr = 1'b0;
        budget = 0;
        while ((gq.size() > 0 || pq.size() > 0) && budget < 50) begin
            g_rd = !g_empty && gq.size() > 0;
            p_rd = !p_empty && pq.size() > 0;
            if (g_rd) begin
                ge = gq.pop_front();
                vectors++;
                if (g_dout !== ge) begin
                    miscompares++;
                    $display("FAIL drain_gray: dout=%h, want %h", g_dout, ge);
                end
            end
            if (p_rd) begin
                pe = pq.pop_front();
                vectors++;
                if (p_dout !== pe) begin
                    miscompares++;
                    $display("FAIL drain_pass: dout=%h, want %h", p_dout, pe);
                end
            end
            tick();
            budget++;
        end
        g_rd = 1'b0;
        p_rd = 1'b0;
        tick();
        vectors++;
        if (gq.size() != 0 || pq.size() != 0 || g_empty !== 1'b1 || p_empty !== 1'b1) begin
            miscompares++;
            $display("FAIL stream_end: left gray=%0d pass=%0d empty=%b/%b, want 0 0 1/1",
                     gq.size(), pq.size(), g_empty, p_empty);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_latency();
        test_gray_vectors();
        test_passthrough();
        test_backpressure();
        test_reset_midstream();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
